ahblite_gpio_debounce: RTL
==========================

Name: ahblite_gpio_debounce

Overview:
Parametrised AHB-Lite GPIO slave, the successor to the fixed 8-switch/8-LED GPIO used on the SoC.
- Input side: WIDTH input channels, each with a 2-flop synchroniser and debounce counter, then per-channel rising/falling edge capture and a masked, level-sensitive interrupt.
- Output side: a WIDTH-bit output register (LEDs).
- Sits on the AHB-Lite decoder/mux like the other peripherals.

Parameters:
- WIDTH, 8, number of input and output channels (1..32).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required before an input change is accepted (>=1).
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address; only bits [4:2] decoded.
- HTRANS  in  2  transfer type; NONSEQ/SEQ are valid, IDLE/BUSY are ignored.
- HWRITE  in  1  write strobe.
- HSIZE  in  3  accepted but ignored; word access assumed.
- HWDATA  in  32  write data.
- HREADY  in  1  bus ready.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  tied 1 (zero wait states).
- HRESP  out  1  tied 0 (OKAY).
- GPIO_IN  in  WIDTH  raw asynchronous inputs (switches).
- GPIO_OUT  out  WIDTH  output register (LEDs).
- IRQ  out  1  interrupt, level-sensitive, active-high.

Behaviour:
- Reset (asynchronous, RESET=1): synchronisers, debounce counters, stable values, all registers, GPIO_OUT and IRQ go to 0; latched address phase is cleared. A debounce in progress is discarded.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. The core registers the word offset and the write flag.
- Writes take effect at the end of the data phase, using HWDATA. Bits above WIDTH are ignored.
- Reads return the selected register in the data phase, zero-extended to 32 bits. Unmapped offsets read 0 and ignore writes.
- Register map (byte offset):
  - 0x00 DATA_IN: RO, debounced stable value.
  - 0x04 DATA_OUT: RW, drives GPIO_OUT directly from the flop.
  - 0x08 EDGE_STAT: W1C, sticky per-channel edge flags.
  - 0x0C IRQ_MASK: RW, 1 = enabled.
  - 0x10 RISE_EN: RW.
  - 0x14 FALL_EN: RW.
- Per channel:
  - sync = 2 flops on GPIO_IN.
  - If sync == stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
  - Any glitch back to the stable value before that point restarts the count.
- Latency from a clean input change to a DATA_IN update is 2 + DEBOUNCE_CYCLES cycles.
- Edge detection on the stable value:
  - rise = stable 0->1 and RISE_EN[i]; fall = stable 1->0 and FALL_EN[i].
  - Either event sets EDGE_STAT[i] on the same clock that stable updates.
- Simultaneous W1C clear and new edge on the same bit: the set wins (flag stays 1).
- IRQ = |(EDGE_STAT & IRQ_MASK), registered, so it asserts one cycle after the flag sets. It deasserts one cycle after the last enabled flag clears.
- Enabling an already-set flag via IRQ_MASK raises IRQ on the next cycle.
- Changing RISE_EN/FALL_EN does not alter flags that are already set.
- A DATA_OUT write followed immediately by a DATA_OUT read returns the new value (zero-wait forwarding is not needed because the write completes before the next data phase).

Decomposition:
- Shared package gpio_pkg holds:
  - register offset constants: OFF_DATA_IN, OFF_DATA_OUT, OFF_EDGE_STAT, OFF_IRQ_MASK, OFF_RISE_EN, OFF_FALL_EN;
  - HTRANS encodings.
- One natural sub-module: gpio_debounce_ch, holding the synchroniser, counter and stable flop for a single channel (params DEBOUNCE_CYCLES, CNT_W; outputs stable, rise_pulse, fall_pulse). It is instantiated WIDTH times in a generate loop.
- The top level holds the AHB-Lite interface, the registers and the IRQ.

Test Plan:
1. Reset then read all offsets -> every read returns 0x00000000; IRQ=0; GPIO_OUT=0.
2. Write 0xA5 to 0x04, then read 0x04 -> GPIO_OUT=8'hA5 one cycle after the data phase; read returns 0x000000A5. Write 0xFFFFFF00 -> GPIO_OUT=0x00.
3. DEBOUNCE_CYCLES=16, GPIO_IN[0] 0->1 held -> DATA_IN reads 0x01 exactly 18 cycles after the change. A 10-cycle pulse -> DATA_IN stays 0x00 and no flag is set.
4. RISE_EN=0x01, IRQ_MASK=0x01, clean rise on GPIO_IN[0] -> EDGE_STAT=0x01 and IRQ=1 one cycle later. Write 0x01 to 0x08 -> EDGE_STAT=0 and IRQ falls the following cycle.
5. FALL_EN=0x80, IRQ_MASK=0: falling edge on bit 7 -> EDGE_STAT=0x80 and IRQ stays 0. Then write IRQ_MASK=0x80 -> IRQ=1 next cycle.
6. W1C of bit 0 in the same cycle a new rising edge sets bit 0 -> EDGE_STAT[0]=1. Assert RESET mid-debounce (count 8) -> all state is 0, and after release a full 18 cycles is needed to accept the input.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO slave.
// Word offsets (HADDR[4:2]) and HTRANS encodings.
package gpio_pkg;

  localparam logic [2:0] OFF_DATA_IN   = 3'd0;
  localparam logic [2:0] OFF_DATA_OUT  = 3'd1;
  localparam logic [2:0] OFF_EDGE_STAT = 3'd2;
  localparam logic [2:0] OFF_IRQ_MASK  = 3'd3;
  localparam logic [2:0] OFF_RISE_EN   = 3'd4;
  localparam logic [2:0] OFF_FALL_EN   = 3'd5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/gpio_debounce_ch.sv
// One GPIO input channel: 2-flop synchroniser,
// debounce counter, stable value and edge pulses.
module gpio_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_stable,
  output logic o_rise_pulse,
  output logic o_fall_pulse
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_accept;

  assign w_diff   = r_s2 ^ r_stable;
  assign w_accept = w_diff & (r_cnt == LAST);

  // synchronise, count stable samples, accept change
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // pulses lead the stable update so flags set on that edge
  assign o_stable     = r_stable;
  assign o_rise_pulse = w_accept & r_s2;
  assign o_fall_pulse = w_accept & ~r_s2;

endmodule

// File: rtl/ahblite_gpio_debounce.sv
// AHB-Lite GPIO slave with debounced inputs,
// sticky edge flags, masked IRQ and LED outputs.
module ahblite_gpio_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic             IRQ
);

  logic             r_valid;
  logic             r_write;
  logic [2:0]       r_off;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic             r_irq;

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rd;
  logic             w_addr_ok;
  logic             w_wr;
  logic             w_we_out;
  logic             w_we_edge;
  logic             w_we_mask;
  logic             w_we_rise;
  logic             w_we_fall;
  logic             w_unused;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      gpio_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_ch (
        .i_clk        (CLK),
        .i_rst        (RESET),
        .i_in         (GPIO_IN[gi]),
        .o_stable     (w_stable[gi]),
        .o_rise_pulse (w_rise[gi]),
        .o_fall_pulse (w_fall[gi])
      );
    end
  endgenerate

  assign w_addr_ok = HSEL & HREADY & HTRANS[1];
  assign w_wr      = r_valid & r_write;
  assign w_wdata   = HWDATA[WIDTH-1:0];

  // latch the address phase for the next data phase
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_off   <= '0;
    end else if (HREADY) begin
      r_valid <= w_addr_ok;
      r_write <= HWRITE;
      r_off   <= HADDR[4:2];
    end
  end

  // decode data-phase write enables
  always_comb begin
    w_we_out  = 1'b0;
    w_we_edge = 1'b0;
    w_we_mask = 1'b0;
    w_we_rise = 1'b0;
    w_we_fall = 1'b0;
    if (w_wr) begin
      unique case (r_off)
        OFF_DATA_OUT:  w_we_out  = 1'b1;
        OFF_EDGE_STAT: w_we_edge = 1'b1;
        OFF_IRQ_MASK:  w_we_mask = 1'b1;
        OFF_RISE_EN:   w_we_rise = 1'b1;
        OFF_FALL_EN:   w_we_fall = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_set = (w_rise & r_rise_en)
               | (w_fall & r_fall_en);
  assign w_clr = w_we_edge ? w_wdata : '0;

  // control registers, sticky flags and IRQ
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_out     <= '0;
      r_edge    <= '0;
      r_mask    <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_we_out)  r_out     <= w_wdata;
      if (w_we_mask) r_mask    <= w_wdata;
      if (w_we_rise) r_rise_en <= w_wdata;
      if (w_we_fall) r_fall_en <= w_wdata;
      r_edge <= (r_edge & ~w_clr) | w_set;
      r_irq  <= |(r_edge & r_mask);
    end
  end

  // data-phase read mux
  always_comb begin
    w_rd = '0;
    if (r_valid && !r_write) begin
      unique case (r_off)
        OFF_DATA_IN:   w_rd = w_stable;
        OFF_DATA_OUT:  w_rd = r_out;
        OFF_EDGE_STAT: w_rd = r_edge;
        OFF_IRQ_MASK:  w_rd = r_mask;
        OFF_RISE_EN:   w_rd = r_rise_en;
        OFF_FALL_EN:   w_rd = r_fall_en;
        default:       w_rd = '0;
      endcase
    end
  end

  assign HRDATA    = 32'(w_rd);
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign GPIO_OUT  = r_out;
  assign IRQ       = r_irq;

  assign w_unused = ^{HSIZE, HADDR[31:5],
                      HADDR[1:0], HTRANS[0],
                      HWDATA};

endmodule
